apple_spawn_ctrl: RTL and testbench
===================================

// Module: apple_spawn_ctrl
// PURPOSE
//  Sequences the apple datapath: detects head-on-apple, updates the score, then
//  picks a new free apple cell inside the play grid. Candidates come from an
//  LFSR. Each candidate is checked against the snake-body occupancy store over a
//  req/ack port. After MAX_TRIES rejected candidates, a row-major scan of the
//  grid picks the cell. Sits between the snake mover and the renderer/score display.
// PARAMETERS
//  INIT_X     20       apple column after reset/game_start (absolute grid units)
//  INIT_Y     19       apple row after reset/game_start
//  LFSR_SEED  16'hACE1 LFSR value loaded on reset only; must be non-zero
//  MAX_TRIES  8        random candidates tried before switching to the scan
//  SCORE_MAX  15       score value that ends the game (WIN)
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high
//  game_start   in   1  1-cycle pulse: restart round (score/apple), LFSR kept
//  head_valid   in   1  1-cycle pulse: head_x/head_y hold the new head position
//  head_x       in   7  snake head column
//  head_y       in   6  snake head row
//  grid_x0      in   7  first playable column
//  grid_y0      in   6  first playable row
//  grid_w       in   7  playable width in cells (1..127)
//  grid_h       in   6  playable height in cells (1..63)
//  occ_req      out  1  occupancy query request
//  occ_x        out  7  queried column; stable while occ_req=1
//  occ_y        out  6  queried row; stable while occ_req=1
//  occ_ack      in   1  1-cycle: query answered, occ_hit valid this cycle
//  occ_hit      in   1  1 = queried cell holds a body segment
//  apple_x      out  7  current apple column
//  apple_y      out  6  current apple row
//  apple_valid  out  1  apple shown and edible
//  eaten        out  1  1-cycle pulse on each eat
//  score        out  4  apples eaten this round
//  win          out  1  high when score reaches SCORE_MAX, until restart
//  busy         out  1  high in PLACE/QUERY/SCAN
// BEHAVIOUR
//  Reset values: apple=(INIT_X,INIT_Y), apple_valid=1, score=0, eaten=0, win=0,
//   occ_req=0, busy=0, state=ACTIVE, tries=0, lfsr=LFSR_SEED.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock, including
//   during game_start; never stalls.
//  ACTIVE: when head_valid && head==apple, next cycle eaten=1 and score+1.
//   Same edge: apple_valid=0, tries=0. If the new score equals SCORE_MAX, go
//   to WIN. Otherwise go to PLACE.
//  PLACE (1 cycle): dx=lfsr[6:0], dy=lfsr[13:8].
//   - If dx>=grid_w or dy>=grid_h: tries+1 and stay in PLACE; no query.
//   - Else latch occ_x=grid_x0+dx and occ_y=grid_y0+dy (7/6-bit, no overflow
//     by contract). Assert occ_req and go to QUERY.
//  QUERY: occ_req is held until the cycle occ_ack=1; it drops on the next edge.
//   - Accept if occ_hit=0 and the candidate is not (head_x,head_y): apple=candidate,
//     apple_valid=1, go to ACTIVE.
//   - Otherwise tries+1 and go to PLACE.
//   - When tries reaches MAX_TRIES in PLACE or QUERY: go to SCAN with the scan
//     cell set to (grid_x0,grid_y0).
//  SCAN: same handshake as QUERY, on the scan cell. The scan cell advances
//   row-major: x+1; past grid_x0+grid_w-1 it returns to grid_x0 and y+1; past the
//   last row it wraps to the origin. The first free cell is accepted.
//   If the grid is full, the scan never ends (upstream guarantees a free cell).
//  Throughput: at most one outstanding query; eaten pulses only from ACTIVE.
//  head_valid outside ACTIVE: no eat; the head position is still used for the
//   exclusion check.
//  WIN: apple_valid=0 and win=1. Stays in WIN until game_start or reset.
//  game_start (any state): same values as reset except the LFSR. An in-flight
//   query is abandoned: occ_req=0 next cycle and a late occ_ack is ignored.
//  Score never wraps: it saturates at SCORE_MAX by construction.
// TESTING
//  1 reset; head_valid at (20,19) -> next cycle eaten=1, score=1, apple_valid=0, busy=1.
//  2 grid (10,5,40,30), occ_hit always 0, ack 2 cycles after req -> apple inside
//    x 10..49, y 5..34; occ_x/occ_y stable while req; apple_valid=1.
//  3 occ_hit=1 for every random candidate -> after 8 rejects SCAN from (10,5);
//    body stub frees only (12,5) -> apple=(12,5).
//  4 15 consecutive eats -> score=15, win=1, apple_valid=0; head_valid ignored
//    until game_start, which gives score=0, apple=(20,19).
//  5 game_start while occ_req=1 -> occ_req=0 next cycle; a late occ_ack does not
//    change the apple; state=ACTIVE.
//  6 random candidate equals the current head with occ_hit=0 -> rejected, tries=1,
//    new query issued.

Source files
------------

// File: rtl/apple_spawn_ctrl_if.sv
// Occupancy query port between the apple spawner and the snake-body store.
// The spawner drives one query at a time; the store answers with a 1-cycle ack.
interface apple_spawn_ctrl_if;
  logic       req;
  logic [6:0] x;
  logic [5:0] y;
  logic       ack;
  logic       hit;

  modport master (output req, x, y, input ack, hit);
  modport slave  (input req, x, y, output ack, hit);
endinterface

// File: rtl/apple_spawn_ctrl.sv
// Apple datapath sequencer: eat detection, score keeping, and placement of a
// new apple on a free grid cell (LFSR candidates first, row-major scan after
// too many rejects).
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_ACTIVE | apple shown; watching for the head landing on it
// S_PLACE  | derive a candidate from the LFSR, range-check it
// S_QUERY  | random candidate query outstanding on the occupancy port
// S_SCAN   | row-major scan; req low for one cycle between scan queries
// S_WIN    | score hit the maximum; frozen until game_start
module apple_spawn_ctrl #(
  parameter int          INIT_X    = 20,
  parameter int          INIT_Y    = 19,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 8,
  parameter int          SCORE_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_game_start,
  input  logic       i_head_valid,
  input  logic [6:0] i_head_x,
  input  logic [5:0] i_head_y,
  input  logic [6:0] i_grid_x0,
  input  logic [5:0] i_grid_y0,
  input  logic [6:0] i_grid_w,
  input  logic [5:0] i_grid_h,
  apple_spawn_ctrl_if.master occ,
  output logic [6:0] o_apple_x,
  output logic [5:0] o_apple_y,
  output logic       o_apple_valid,
  output logic       o_eaten,
  output logic [3:0] o_score,
  output logic       o_win,
  output logic       o_busy
);
  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {S_ACTIVE, S_PLACE, S_QUERY, S_SCAN, S_WIN} state_t;

  state_t          r_state,   w_state_nxt;
  logic [15:0]     r_lfsr;
  logic [TW-1:0]   r_tries,   w_tries_nxt;
  logic [6:0]      r_apple_x, w_apple_x_nxt;
  logic [5:0]      r_apple_y, w_apple_y_nxt;
  logic            r_apple_v, w_apple_v_nxt;
  logic            r_eaten,   w_eaten_nxt;
  logic [3:0]      r_score,   w_score_nxt;
  logic            r_req,     w_req_nxt;
  logic [6:0]      r_qx,      w_qx_nxt;
  logic [5:0]      r_qy,      w_qy_nxt;

  logic [6:0]      w_dx;
  logic [5:0]      w_dy;
  logic [3:0]      w_score_inc;
  logic [TW-1:0]   w_tries_inc;
  logic [6:0]      w_last_col;
  logic [5:0]      w_last_row;
  logic            w_free;

  assign w_dx        = r_lfsr[6:0];
  assign w_dy        = r_lfsr[13:8];
  assign w_score_inc = r_score + 4'd1;
  assign w_tries_inc = r_tries + TW'(1);
  assign w_last_col  = i_grid_x0 + i_grid_w - 7'd1;
  assign w_last_row  = i_grid_y0 + i_grid_h - 6'd1;
  // A cell is free only if the body store says so and the head is not on it.
  assign w_free      = !occ.hit && !((r_qx == i_head_x) && (r_qy == i_head_y));

  // Free-running LFSR (taps 16,14,13,11); game_start does not reseed it.
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_ACTIVE;
      r_tries   <= '0;
      r_apple_x <= 7'(INIT_X);
      r_apple_y <= 6'(INIT_Y);
      r_apple_v <= 1'b1;
      r_eaten   <= 1'b0;
      r_score   <= 4'd0;
      r_req     <= 1'b0;
      r_qx      <= 7'd0;
      r_qy      <= 6'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_tries   <= w_tries_nxt;
      r_apple_x <= w_apple_x_nxt;
      r_apple_y <= w_apple_y_nxt;
      r_apple_v <= w_apple_v_nxt;
      r_eaten   <= w_eaten_nxt;
      r_score   <= w_score_nxt;
      r_req     <= w_req_nxt;
      r_qx      <= w_qx_nxt;
      r_qy      <= w_qy_nxt;
    end
  end

  // Next-state and datapath updates; game_start overrides every state.
  always_comb begin
    w_state_nxt   = r_state;
    w_tries_nxt   = r_tries;
    w_apple_x_nxt = r_apple_x;
    w_apple_y_nxt = r_apple_y;
    w_apple_v_nxt = r_apple_v;
    w_eaten_nxt   = 1'b0;
    w_score_nxt   = r_score;
    w_req_nxt     = r_req;
    w_qx_nxt      = r_qx;
    w_qy_nxt      = r_qy;
    if (i_game_start) begin
      w_state_nxt   = S_ACTIVE;
      w_tries_nxt   = '0;
      w_apple_x_nxt = 7'(INIT_X);
      w_apple_y_nxt = 6'(INIT_Y);
      w_apple_v_nxt = 1'b1;
      w_score_nxt   = 4'd0;
      w_req_nxt     = 1'b0;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          if (i_head_valid && (i_head_x == r_apple_x) && (i_head_y == r_apple_y)) begin
            w_eaten_nxt   = 1'b1;
            w_score_nxt   = w_score_inc;
            w_apple_v_nxt = 1'b0;
            w_tries_nxt   = '0;
            w_state_nxt   = (w_score_inc == 4'(SCORE_MAX)) ? S_WIN : S_PLACE;
          end
        end
        S_PLACE: begin
          if ((w_dx >= i_grid_w) || (w_dy >= i_grid_h)) begin
            w_tries_nxt = w_tries_inc;
            if (w_tries_inc == TW'(MAX_TRIES)) begin
              w_state_nxt = S_SCAN;
              w_qx_nxt    = i_grid_x0;
              w_qy_nxt    = i_grid_y0;
            end
          end else begin
            w_qx_nxt    = i_grid_x0 + w_dx;
            w_qy_nxt    = i_grid_y0 + w_dy;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_QUERY;
          end
        end
        S_QUERY: begin
          if (occ.ack) begin
            w_req_nxt = 1'b0;
            if (w_free) begin
              w_apple_x_nxt = r_qx;
              w_apple_y_nxt = r_qy;
              w_apple_v_nxt = 1'b1;
              w_state_nxt   = S_ACTIVE;
            end else begin
              w_tries_nxt = w_tries_inc;
              if (w_tries_inc == TW'(MAX_TRIES)) begin
                w_state_nxt = S_SCAN;
                w_qx_nxt    = i_grid_x0;
                w_qy_nxt    = i_grid_y0;
              end else begin
                w_state_nxt = S_PLACE;
              end
            end
          end
        end
        S_SCAN: begin
          if (!r_req) begin
            w_req_nxt = 1'b1;
          end else if (occ.ack) begin
            w_req_nxt = 1'b0;
            if (w_free) begin
              w_apple_x_nxt = r_qx;
              w_apple_y_nxt = r_qy;
              w_apple_v_nxt = 1'b1;
              w_state_nxt   = S_ACTIVE;
            end else if (r_qx == w_last_col) begin
              w_qx_nxt = i_grid_x0;
              w_qy_nxt = (r_qy == w_last_row) ? i_grid_y0 : r_qy + 6'd1;
            end else begin
              w_qx_nxt = r_qx + 7'd1;
            end
          end
        end
        S_WIN:   w_apple_v_nxt = 1'b0;
        default: w_state_nxt   = S_ACTIVE;
      endcase
    end
  end

  assign occ.req       = r_req;
  assign occ.x         = r_qx;
  assign occ.y         = r_qy;
  assign o_apple_x     = r_apple_x;
  assign o_apple_y     = r_apple_y;
  assign o_apple_valid = r_apple_v;
  assign o_eaten       = r_eaten;
  assign o_score       = r_score;
  assign o_win         = (r_state == S_WIN);
  assign o_busy        = (r_state == S_PLACE) || (r_state == S_QUERY) || (r_state == S_SCAN);
endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Bench for apple_spawn_ctrl: event-level model of the spawn algorithm,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_apple_spawn_ctrl;
  localparam int PH_ACT = 0, PH_RAND = 1, PH_SCAN = 2, PH_WON = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       game_start = 1'b0, head_valid = 1'b0;
  logic [6:0] head_x = 7'd0, grid_x0 = 7'd10, grid_w = 7'd40;
  logic [5:0] head_y = 6'd0, grid_y0 = 6'd5,  grid_h = 6'd30;
  logic [6:0] apple_x;
  logic [5:0] apple_y;
  logic       apple_valid, eaten, win, busy;
  logic [3:0] score;

  int vectors = 0, miscompares = 0;
  int mode = 0;          // 0: body never hits; 1: every random candidate hits, scan frees only (12,5)
  bit resp_en = 1'b1;

  apple_spawn_ctrl_if occ_bus ();

  apple_spawn_ctrl dut (
    .clk(clk), .reset(reset), .i_game_start(game_start), .i_head_valid(head_valid),
    .i_head_x(head_x), .i_head_y(head_y), .i_grid_x0(grid_x0), .i_grid_y0(grid_y0),
    .i_grid_w(grid_w), .i_grid_h(grid_h), .occ(occ_bus),
    .o_apple_x(apple_x), .o_apple_y(apple_y), .o_apple_valid(apple_valid),
    .o_eaten(eaten), .o_score(score), .o_win(win), .o_busy(busy));

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  // ---------------- model ----------------
  logic [15:0] m_lfsr = 16'h0;
  int m_phase = PH_ACT, m_score = 0, m_tries = 0;
  int m_ax = 20, m_ay = 19, m_cx = 0, m_cy = 0, m_sx = 0, m_sy = 0;
  bit m_req = 0, m_eaten = 0;
  bit pv_reset = 1, pv_gs = 0, pv_hv = 0, pv_ack = 0, pv_hit = 0;
  int pv_hx = 0, pv_hy = 0, pv_gx0 = 0, pv_gy0 = 0, pv_gw = 1, pv_gh = 1;

  task automatic model_reject_random();
    m_tries++;
    if (m_tries == 8) begin
      m_phase = PH_SCAN;
      m_sx = pv_gx0;
      m_sy = pv_gy0;
    end
  endtask

  always @(negedge clk) begin
    int dx, dy;
    bit free;
    m_eaten = 0;
    if (pv_reset || pv_gs) begin
      m_phase = PH_ACT; m_score = 0; m_ax = 20; m_ay = 19; m_req = 0; m_tries = 0;
    end else begin
      case (m_phase)
        PH_ACT: if (pv_hv && pv_hx == m_ax && pv_hy == m_ay) begin
          m_eaten = 1;
          m_score++;
          m_tries = 0;
          m_phase = (m_score == 15) ? PH_WON : PH_RAND;
        end
        PH_RAND, PH_SCAN: begin
          if (!m_req) begin
            if (m_phase == PH_SCAN) begin
              m_req = 1; m_cx = m_sx; m_cy = m_sy;
            end else begin
              dx = int'(m_lfsr[6:0]);
              dy = int'(m_lfsr[13:8]);
              if (dx >= pv_gw || dy >= pv_gh) model_reject_random();
              else begin
                m_req = 1;
                m_cx = (pv_gx0 + dx) % 128;
                m_cy = (pv_gy0 + dy) % 64;
              end
            end
          end else if (pv_ack) begin
            m_req = 0;
            free = !pv_hit && !(m_cx == pv_hx && m_cy == pv_hy);
            if (free) begin
              m_ax = m_cx; m_ay = m_cy; m_phase = PH_ACT;
            end else if (m_phase == PH_RAND) begin
              model_reject_random();
            end else begin
              if (m_sx == pv_gx0 + pv_gw - 1) begin
                m_sx = pv_gx0;
                m_sy = (m_sy == pv_gy0 + pv_gh - 1) ? pv_gy0 : m_sy + 1;
              end else m_sx++;
            end
          end
        end
        default: ;
      endcase
    end
    m_lfsr = pv_reset ? 16'hACE1 : lfsr_next(m_lfsr);

    chk("occ_req", occ_bus.req, m_req);
    if (m_req) begin
      chk("occ_x", occ_bus.x, m_cx);
      chk("occ_y", occ_bus.y, m_cy);
    end
    chk("apple_x", apple_x, m_ax);
    chk("apple_y", apple_y, m_ay);
    chk("apple_valid", apple_valid, (m_phase == PH_ACT) ? 1 : 0);
    chk("eaten", eaten, m_eaten);
    chk("score", score, m_score);
    chk("win", win, (m_phase == PH_WON) ? 1 : 0);
    chk("busy", busy, (m_phase == PH_RAND || m_phase == PH_SCAN) ? 1 : 0);

    pv_reset = reset; pv_gs = game_start; pv_hv = head_valid;
    pv_hx = head_x; pv_hy = head_y; pv_ack = occ_bus.ack; pv_hit = occ_bus.hit;
    pv_gx0 = grid_x0; pv_gy0 = grid_y0; pv_gw = grid_w; pv_gh = grid_h;
  end

  // ---------------- occupancy store responder ----------------
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!resp_en) begin cnt = 0; continue; end
      if (occ_bus.ack) begin
        occ_bus.ack = 1'b0; cnt = 0;
      end else if (occ_bus.req) begin
        cnt++;
        if (cnt >= 2) begin
          occ_bus.ack = 1'b1;
          if (mode == 1)
            occ_bus.hit = !(m_phase == PH_SCAN && occ_bus.x == 7'd12 && occ_bus.y == 6'd5);
          else
            occ_bus.hit = 1'b0;
          cnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic eat(input int exp_score);
    step(); head_valid = 1'b1; head_x = 7'(m_ax); head_y = 6'(m_ay);
    step(); head_valid = 1'b0; head_x = 7'd0; head_y = 6'd0;
    @(negedge clk);
    chk("eat_pulse", eaten, 1);
    chk("eat_score", score, exp_score);
    chk("eat_apple_valid", apple_valid, 0);
  endtask

  task automatic wait_req(input logic lvl, input string nm);
    int n = 0;
    @(negedge clk);
    while (occ_bus.req !== lvl && n < 500) begin @(negedge clk); n++; end
    if (occ_bus.req !== lvl) timeout(nm);
  endtask

  task automatic wait_placed(input string nm);
    int n = 0;
    @(negedge clk);
    while (!(apple_valid === 1'b1 || win === 1'b1) && n < 3000) begin @(negedge clk); n++; end
    if (!(apple_valid === 1'b1 || win === 1'b1)) timeout(nm);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] l1, l2;
    occ_bus.ack = 1'b0; occ_bus.hit = 1'b0;
    l1 = lfsr_next(16'hACE1);
    l2 = lfsr_next(l1);
    chk("lfsr_model_step1", l1, 16'h59C3);
    chk("lfsr_model_step2", l2, 16'hB387);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_apple_x", apple_x, 20);
    chk("rst_apple_y", apple_y, 19);
    chk("rst_apple_valid", apple_valid, 1);
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", occ_bus.req, 0);
    step(); reset = 1'b0;

    // 1: eat at the reset apple
    eat(1);
    chk("t1_busy", busy, 1);

    // 2: random placement inside grid (10,5,40,30)
    wait_placed("t2_place");
    chk("t2_x_in_grid", (apple_x >= 10 && apple_x <= 49) ? 1 : 0, 1);
    chk("t2_y_in_grid", (apple_y >= 5 && apple_y <= 34) ? 1 : 0, 1);
    chk("t2_apple_valid", apple_valid, 1);

    // 3: all random candidates occupied -> scan finds (12,5)
    step(); mode = 1;
    eat(2);
    wait_placed("t3_place");
    chk("t3_apple_x", apple_x, 12);
    chk("t3_apple_y", apple_y, 5);

    // 6: candidate equal to head is rejected and a new query follows
    step(); mode = 0;
    eat(3);
    wait_req(1'b1, "t6_req");
    step(); head_x = 7'(m_cx); head_y = 6'(m_cy);
    wait_req(1'b0, "t6_reject");
    chk("t6_rejected_valid", apple_valid, 0);
    chk("t6_still_busy", busy, 1);
    wait_req(1'b1, "t6_requery");
    step(); head_x = 7'd0; head_y = 6'd0;
    wait_placed("t6_place");

    // 5: game_start abandons an in-flight query; late ack ignored
    step(); resp_en = 1'b0;
    eat(4);
    wait_req(1'b1, "t5_req");
    step(); game_start = 1'b1;
    step(); game_start = 1'b0;
    @(negedge clk);
    chk("t5_req_dropped", occ_bus.req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_score", score, 0);
    step(); occ_bus.ack = 1'b1; occ_bus.hit = 1'b0;
    step(); occ_bus.ack = 1'b0;
    @(negedge clk);
    chk("t5_apple_x", apple_x, 20);
    chk("t5_apple_y", apple_y, 19);
    chk("t5_apple_valid", apple_valid, 1);
    step(); resp_en = 1'b1;

    // 4: fifteen eats -> WIN, head ignored, game_start restarts
    for (int i = 1; i <= 15; i++) begin
      eat(i);
      if (i < 15) wait_placed("t4_place");
    end
    chk("t4_score", score, 15);
    chk("t4_win", win, 1);
    chk("t4_apple_valid", apple_valid, 0);
    step(); head_valid = 1'b1; head_x = 7'(m_ax); head_y = 6'(m_ay);
    step(); head_valid = 1'b0;
    @(negedge clk);
    chk("t4_no_eat_in_win", eaten, 0);
    chk("t4_score_held", score, 15);
    step(); game_start = 1'b1;
    step(); game_start = 1'b0;
    @(negedge clk);
    chk("t4_restart_score", score, 0);
    chk("t4_restart_win", win, 0);
    chk("t4_restart_x", apple_x, 20);
    chk("t4_restart_y", apple_y, 19);
    chk("t4_restart_valid", apple_valid, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
